// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {ARB_CPU, ARB_EXT, ARB_YIELD} arb_state_t;

  typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

  typedef struct packed {
    logic   vld;
    owner_t owner;
  } rd_tag_t;

  localparam int MAX_WAIT_DEF  = 4;
  localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/dmem_port_arbiter_rd_tag_pipe.sv
// Delay line carrying {valid, owner} for each granted read until ram_q is valid.
module rd_tag_pipe
  import dmem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_p0,
  output rd_tag_t tag_pn
);

  rd_tag_t pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_p0;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_pn = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage and an
// external loader/debug port, and routes read data back to its owner.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall_pipe,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  rd_tag_t            tag_p0, tag_pn;
  logic [DATA_W-1:0]  cpu_rdata_q, ext_rdata_q;

  // Grant decode and next state; reset suppresses any RAM access this cycle.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    if (!reset) begin
      case (state_q)
        ARB_CPU: begin
          if (cpu_req) begin
            cpu_gnt = 1'b1;
            if (ext_req) begin
              if (wait_q < WAIT_W'(MAX_WAIT)) wait_d = wait_q + 1'b1;
              if (wait_d == WAIT_W'(MAX_WAIT)) state_d = ARB_EXT;
            end
          end else if (ext_req) begin
            ext_gnt = 1'b1;
            wait_d  = '0;
            if (ext_lock) state_d = ARB_EXT;
          end
        end
        ARB_EXT: begin
          if (ext_req) begin
            ext_gnt = 1'b1;
            burst_d = burst_q + 1'b1;
            if (!ext_lock) state_d = ARB_CPU;
            else if (burst_q == BURST_W'(MAX_BURST - 1)) state_d = ARB_YIELD;
          end else begin
            cpu_gnt = cpu_req;
            state_d = ARB_CPU;
          end
        end
        ARB_YIELD: begin
          cpu_gnt = cpu_req;
          state_d = ARB_CPU;
        end
        default: state_d = ARB_CPU;
      endcase
      if (state_d != state_q) begin
        wait_d  = '0;
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_CPU;
      wait_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
    end
  end

  assign stall_pipe  = cpu_req & ~cpu_gnt;
  assign ram_wren    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
  assign ram_address = cpu_gnt ? cpu_addr  : (ext_gnt ? ext_addr  : '0);
  assign ram_data    = cpu_gnt ? cpu_wdata : (ext_gnt ? ext_wdata : '0);

  assign tag_p0.vld   = (cpu_gnt & ~cpu_we) | (ext_gnt & ~ext_we);
  assign tag_p0.owner = ext_gnt ? OWN_EXT : OWN_CPU;

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk    (clk),
    .reset  (reset),
    .tag_p0 (tag_p0),
    .tag_pn (tag_pn)
  );

  // Return stage: the owner sees ram_q, the other side keeps its last word.
  assign cpu_rvalid = tag_pn.vld & (tag_pn.owner == OWN_CPU) & ~reset;
  assign ext_rvalid = tag_pn.vld & (tag_pn.owner == OWN_EXT) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= ram_q;
      if (ext_rvalid) ext_rdata_q <= ram_q;
    end
  end

  assign cpu_rdata = cpu_rvalid ? ram_q : cpu_rdata_q;
  assign ext_rdata = ext_rvalid ? ram_q : ext_rdata_q;

endmodule
